id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register for the RV32 pipeline, sitting directly upstream of the EX-stage ALU.
- Captures decoded instruction fields on each clock and holds them on stall; on flush it inserts a bubble.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then selects the operands.
- Drives the ALU's SrcA, SrcB and 4-bit Operation directly.

---
 rtl/id_ex_operand_stage_pkg.sv | 23 ++
 rtl/id_ex_operand_stage_if.sv | 50 +++++
 rtl/id_ex_operand_stage_fwd_mux.sv | 36 +++
 rtl/id_ex_operand_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared RV32 pipeline encodings: ALU operation codes, SrcA select and forwarding source.
package riscv_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_EQ   = 4'b0101;
  localparam logic [3:0] ALU_NE   = 4'b0110;
  localparam logic [3:0] ALU_LT   = 4'b0111;
  localparam logic [3:0] ALU_GE   = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_TRUE = 4'b1111;

  // Encoding 3 is reserved and behaves like A_ZERO.
  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} a_sel_e;

  typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_WB = 2'd1, FWD_MEM = 2'd2} fwd_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between the decode/hazard side and the ID/EX operand stage, including bypass sources.
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int OPCODE_LENGTH = 4
);
  logic                     stall;
  logic                     flush;
  logic                     id_valid;
  logic [REG_ADDR_W-1:0]    id_rs1;
  logic [REG_ADDR_W-1:0]    id_rs2;
  logic [REG_ADDR_W-1:0]    id_rd;
  logic [DATA_WIDTH-1:0]    id_rs1_data;
  logic [DATA_WIDTH-1:0]    id_rs2_data;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic [DATA_WIDTH-1:0]    id_pc;
  logic [1:0]               id_a_sel;
  logic                     id_b_imm;
  logic [OPCODE_LENGTH-1:0] id_alu_op;
  logic                     id_reg_write;
  logic [REG_ADDR_W-1:0]    mem_rd;
  logic                     mem_reg_write;
  logic [DATA_WIDTH-1:0]    mem_result;
  logic [REG_ADDR_W-1:0]    wb_rd;
  logic                     wb_reg_write;
  logic [DATA_WIDTH-1:0]    wb_result;
  logic                     ex_valid;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [REG_ADDR_W-1:0]    ex_rd;
  logic                     ex_reg_write;
  logic [DATA_WIDTH-1:0]    ex_store_data;
  logic [1:0]               fwd_a;
  logic [1:0]               fwd_b;

  modport master (
    output stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_pc, id_a_sel, id_b_imm, id_alu_op, id_reg_write,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    input  ex_valid, SrcA, SrcB, Operation, ex_rd, ex_reg_write, ex_store_data, fwd_a, fwd_b
  );

  modport slave (
    input  stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_pc, id_a_sel, id_b_imm, id_alu_op, id_reg_write,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    output ex_valid, SrcA, SrcB, Operation, ex_rd, ex_reg_write, ex_store_data, fwd_a, fwd_b
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Bypass selector for one source register: MEM beats WB, x0 never bypasses.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_reg_write_i,
  input  logic [DATA_WIDTH-1:0] mem_result_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_reg_write_i,
  input  logic [DATA_WIDTH-1:0] wb_result_i,
  output logic [DATA_WIDTH-1:0] value_o,
  output fwd_e                  fwd_o
);
  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_i);
  assign wb_hit  = wb_reg_write_i  && (wb_rd_i  != '0) && (wb_rd_i  == rs_i);

  always_comb begin
    value_o = rf_data_i;
    fwd_o   = FWD_NONE;
    if (mem_hit) begin
      value_o = mem_result_i;
      fwd_o   = FWD_MEM;
    end else if (wb_hit) begin
      value_o = wb_result_i;
      fwd_o   = FWD_WB;
    end
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with stall/flush control; operands are re-bypassed every cycle
// from the held fields so a producer advancing during a stall is still observed.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int OPCODE_LENGTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  id_ex_operand_stage_if.slave bus
);
  logic                     valid_q,     valid_d;
  logic [REG_ADDR_W-1:0]    rs1_q,       rs1_d;
  logic [REG_ADDR_W-1:0]    rs2_q,       rs2_d;
  logic [REG_ADDR_W-1:0]    rd_q,        rd_d;
  logic [DATA_WIDTH-1:0]    rs1_data_q,  rs1_data_d;
  logic [DATA_WIDTH-1:0]    rs2_data_q,  rs2_data_d;
  logic [DATA_WIDTH-1:0]    imm_q,       imm_d;
  logic [DATA_WIDTH-1:0]    pc_q,        pc_d;
  logic [1:0]               a_sel_q,     a_sel_d;
  logic                     b_imm_q,     b_imm_d;
  logic [OPCODE_LENGTH-1:0] alu_op_q,    alu_op_d;
  logic                     reg_write_q, reg_write_d;

  logic [DATA_WIDTH-1:0]    rs1_fwd;
  logic [DATA_WIDTH-1:0]    rs2_fwd;
  fwd_e                     fwd_a_sel;
  fwd_e                     fwd_b_sel;
  logic [DATA_WIDTH-1:0]    src_a;

  // Flush outranks stall; a bubble clears every field, data included.
  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    a_sel_d     = a_sel_q;
    b_imm_d     = b_imm_q;
    alu_op_d    = alu_op_q;
    reg_write_d = reg_write_q;
    if (bus.flush) begin
      valid_d     = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      pc_d        = '0;
      a_sel_d     = '0;
      b_imm_d     = 1'b0;
      alu_op_d    = '0;
      reg_write_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = bus.id_valid;
      rs1_d       = bus.id_rs1;
      rs2_d       = bus.id_rs2;
      rd_d        = bus.id_rd;
      rs1_data_d  = bus.id_rs1_data;
      rs2_data_d  = bus.id_rs2_data;
      imm_d       = bus.id_imm;
      pc_d        = bus.id_pc;
      a_sel_d     = bus.id_a_sel;
      b_imm_d     = bus.id_b_imm;
      alu_op_d    = bus.id_alu_op;
      reg_write_d = bus.id_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      a_sel_q     <= '0;
      b_imm_q     <= 1'b0;
      alu_op_q    <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      a_sel_q     <= a_sel_d;
      b_imm_q     <= b_imm_d;
      alu_op_q    <= alu_op_d;
      reg_write_q <= reg_write_d;
    end
  end

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_i(rs1_q), .rf_data_i(rs1_data_q),
    .mem_rd_i(bus.mem_rd), .mem_reg_write_i(bus.mem_reg_write), .mem_result_i(bus.mem_result),
    .wb_rd_i(bus.wb_rd), .wb_reg_write_i(bus.wb_reg_write), .wb_result_i(bus.wb_result),
    .value_o(rs1_fwd), .fwd_o(fwd_a_sel)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_i(rs2_q), .rf_data_i(rs2_data_q),
    .mem_rd_i(bus.mem_rd), .mem_reg_write_i(bus.mem_reg_write), .mem_result_i(bus.mem_result),
    .wb_rd_i(bus.wb_rd), .wb_reg_write_i(bus.wb_reg_write), .wb_result_i(bus.wb_result),
    .value_o(rs2_fwd), .fwd_o(fwd_b_sel)
  );

  always_comb begin
    src_a = '0;
    case (a_sel_q)
      A_RS1:   src_a = rs1_fwd;
      A_PC:    src_a = pc_q;
      default: src_a = '0;
    endcase
  end

  assign bus.ex_valid      = valid_q;
  assign bus.SrcA          = src_a;
  assign bus.SrcB          = b_imm_q ? imm_q : rs2_fwd;
  assign bus.Operation     = alu_op_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q & valid_q;
  assign bus.ex_store_data = rs2_fwd;
  assign bus.fwd_a         = fwd_a_sel;
  assign bus.fwd_b         = fwd_b_sel;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scenarios plus a randomized run checked against a slot-level reference model.
module tb_id_ex_operand_stage;
  import riscv_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  id_ex_operand_stage_if #(.DATA_WIDTH(32), .REG_ADDR_W(5), .OPCODE_LENGTH(4)) bus ();

  id_ex_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: contents of the EX slot as the instruction-level rules describe them.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic [3:0]  op;
    logic        rw;
  } slot_t;
  slot_t m;

  function automatic void fwd_ref(input logic [4:0] rs, input logic [31:0] rf,
                                  output logic [31:0] v, output logic [1:0] c);
    if (rs != 5'd0 && bus.mem_reg_write && bus.mem_rd == rs) begin
      v = bus.mem_result; c = 2'd2;
    end else if (rs != 5'd0 && bus.wb_reg_write && bus.wb_rd == rs) begin
      v = bus.wb_result;  c = 2'd1;
    end else begin
      v = rf;             c = 2'd0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset || bus.flush) m = '0;
    else if (!bus.stall) begin
      m.valid = bus.id_valid;  m.rs1 = bus.id_rs1;  m.rs2 = bus.id_rs2;  m.rd = bus.id_rd;
      m.rs1_data = bus.id_rs1_data;  m.rs2_data = bus.id_rs2_data;
      m.imm = bus.id_imm;  m.pc = bus.id_pc;  m.a_sel = bus.id_a_sel;
      m.b_imm = bus.id_b_imm;  m.op = bus.id_alu_op;  m.rw = bus.id_reg_write;
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [1:0] asel, input logic bimm,
                        input logic [3:0] op, input logic rw);
    bus.id_valid = v;  bus.id_rs1 = r1;  bus.id_rs2 = r2;  bus.id_rd = rd;
    bus.id_rs1_data = d1;  bus.id_rs2_data = d2;  bus.id_imm = imm;  bus.id_pc = pc;
    bus.id_a_sel = asel;  bus.id_b_imm = bimm;  bus.id_alu_op = op;  bus.id_reg_write = rw;
  endtask

  task automatic set_id_random();
    set_id(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
           $urandom, $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic clear_bypass();
    bus.mem_reg_write = 1'b0;  bus.mem_rd = '0;  bus.mem_result = '0;
    bus.wb_reg_write  = 1'b0;  bus.wb_rd  = '0;  bus.wb_result  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;  bus.stall = 1'b0;  bus.flush = 1'b0;
    clear_bypass();
    set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h1234, 32'h5678, 32'h9, 32'h400, 2'd0, 1'b0, ALU_SUB, 1'b1);
    tick();
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.ex_valid); end
    checks++; if (bus.ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%0b exp=0", bus.ex_reg_write); end
    checks++; if (bus.Operation !== 4'b0000) begin errors++; $display("FAIL reset_op got=%b exp=0000", bus.Operation); end
    checks++; if (bus.ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", bus.ex_rd); end
    checks++; if (bus.SrcA !== 32'h0) begin errors++; $display("FAIL reset_srca got=%h exp=0", bus.SrcA); end
    reset = 1'b0;
    $display("txn reset: valid=%0b op=%b rd=%0d", bus.ex_valid, bus.Operation, bus.ex_rd);
  endtask

  task automatic test_basic_add();
    clear_bypass();
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'h0, 32'h100, 2'd0, 1'b0, ALU_ADD, 1'b1);
    tick();
    checks++; if (bus.SrcA !== 32'd5) begin errors++; $display("FAIL add_srca got=%h exp=%h", bus.SrcA, 32'd5); end
    checks++; if (bus.SrcB !== 32'd7) begin errors++; $display("FAIL add_srcb got=%h exp=%h", bus.SrcB, 32'd7); end
    checks++; if (bus.Operation !== 4'b0011) begin errors++; $display("FAIL add_op got=%b exp=0011", bus.Operation); end
    checks++; if (bus.fwd_a !== 2'd0 || bus.fwd_b !== 2'd0) begin errors++; $display("FAIL add_fwd got=%0d/%0d exp=0/0", bus.fwd_a, bus.fwd_b); end
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_reg_write !== 1'b1 || bus.ex_rd !== 5'd5) begin
      errors++; $display("FAIL add_ctrl got=v%0b w%0b rd%0d exp=v1 w1 rd5", bus.ex_valid, bus.ex_reg_write, bus.ex_rd);
    end
    $display("txn add: A=%h B=%h op=%b", bus.SrcA, bus.SrcB, bus.Operation);
  endtask

  task automatic test_fwd_priority();
    clear_bypass();
    set_id(1'b1, 5'd3, 5'd0, 5'd6, 32'h99, 32'h0, 32'h0, 32'h104, 2'd0, 1'b0, ALU_OR, 1'b1);
    tick();
    bus.mem_rd = 5'd3;  bus.mem_result = 32'h11;  bus.mem_reg_write = 1'b1;
    bus.wb_rd  = 5'd3;  bus.wb_result  = 32'h22;  bus.wb_reg_write  = 1'b1;
    #1;
    checks++; if (bus.SrcA !== 32'h11 || bus.fwd_a !== 2'd2) begin errors++; $display("FAIL fwd_mem got=%h/%0d exp=11/2", bus.SrcA, bus.fwd_a); end
    bus.mem_reg_write = 1'b0;
    #1;
    checks++; if (bus.SrcA !== 32'h22 || bus.fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_wb got=%h/%0d exp=22/1", bus.SrcA, bus.fwd_a); end
    bus.wb_reg_write = 1'b0;
    #1;
    checks++; if (bus.SrcA !== 32'h99 || bus.fwd_a !== 2'd0) begin errors++; $display("FAIL fwd_none got=%h/%0d exp=99/0", bus.SrcA, bus.fwd_a); end
    $display("txn fwd_priority: A=%h fwd_a=%0d", bus.SrcA, bus.fwd_a);
  endtask

  task automatic test_rs0_and_imm();
    clear_bypass();
    bus.mem_rd = 5'd0;  bus.mem_result = 32'hDEAD;  bus.mem_reg_write = 1'b1;
    set_id(1'b1, 5'd4, 5'd0, 5'd1, 32'h1, 32'h0, 32'h0, 32'h108, 2'd0, 1'b0, ALU_XOR, 1'b1);
    tick();
    checks++; if (bus.SrcB !== 32'h0 || bus.fwd_b !== 2'd0) begin errors++; $display("FAIL rs0_nofwd got=%h/%0d exp=0/0", bus.SrcB, bus.fwd_b); end
    bus.mem_rd = 5'd6;  bus.mem_result = 32'h77;
    set_id(1'b1, 5'd4, 5'd6, 5'd2, 32'h1, 32'h55, 32'hFFFF_FFFC, 32'h10C, 2'd1, 1'b1, ALU_ADD, 1'b0);
    tick();
    checks++; if (bus.SrcB !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_srcb got=%h exp=fffffffc", bus.SrcB); end
    checks++; if (bus.ex_store_data !== 32'h77 || bus.fwd_b !== 2'd2) begin errors++; $display("FAIL imm_store got=%h/%0d exp=77/2", bus.ex_store_data, bus.fwd_b); end
    checks++; if (bus.SrcA !== 32'h10C) begin errors++; $display("FAIL pc_srca got=%h exp=10c", bus.SrcA); end
    $display("txn rs0_imm: B=%h store=%h", bus.SrcB, bus.ex_store_data);
  endtask

  task automatic test_stall_hold();
    logic [31:0] exp_a;
    clear_bypass();
    set_id(1'b1, 5'd8, 5'd9, 5'd7, 32'h40, 32'h10, 32'h0, 32'h200, 2'd0, 1'b0, ALU_SUB, 1'b1);
    tick();
    bus.stall = 1'b1;
    exp_a = 32'h40;
    for (int i = 0; i < 3; i++) begin
      set_id_random();
      tick();
      checks++; if (bus.SrcA !== exp_a || bus.SrcB !== 32'h10 || bus.Operation !== ALU_SUB || bus.ex_rd !== 5'd7) begin
        errors++; $display("FAIL stall_hold%0d got=%h/%h/%b/%0d exp=%h/10/0100/7", i, bus.SrcA, bus.SrcB, bus.Operation, bus.ex_rd, exp_a);
      end
      if (i == 0) begin
        bus.mem_rd = 5'd8;  bus.mem_result = 32'hABC;  bus.mem_reg_write = 1'b1;
        exp_a = 32'hABC;
        #1;
        checks++; if (bus.SrcA !== 32'hABC || bus.fwd_a !== 2'd2) begin errors++; $display("FAIL stall_refwd got=%h/%0d exp=abc/2", bus.SrcA, bus.fwd_a); end
      end
    end
    bus.stall = 1'b0;
    clear_bypass();
    $display("txn stall: A=%h B=%h op=%b", bus.SrcA, bus.SrcB, bus.Operation);
  endtask

  task automatic test_flush_and_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 32'h300, 2'd0, 1'b0, ALU_SLL, 1'b1);
    tick();
    bus.flush = 1'b1;  bus.stall = 1'b1;
    tick();
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.Operation !== 4'b0000 || bus.ex_rd !== 5'd0) begin
      errors++; $display("FAIL flush_bubble got=v%0b w%0b op%b rd%0d exp=v0 w0 op0000 rd0", bus.ex_valid, bus.ex_reg_write, bus.Operation, bus.ex_rd);
    end
    bus.flush = 1'b0;  bus.stall = 1'b0;
    tick();
    bus.stall = 1'b1;
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.Operation !== ALU_SLL) begin errors++; $display("FAIL stall_before_reset got=v%0b op%b exp=v1 op1010", bus.ex_valid, bus.Operation); end
    reset = 1'b1;
    tick();
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.Operation !== 4'b0000 || bus.ex_rd !== 5'd0) begin
      errors++; $display("FAIL reset_midstall got=v%0b w%0b op%b rd%0d exp=v0 w0 op0000 rd0", bus.ex_valid, bus.ex_reg_write, bus.Operation, bus.ex_rd);
    end
    reset = 1'b0;  bus.stall = 1'b0;
    $display("txn flush_reset: valid=%0b op=%b", bus.ex_valid, bus.Operation);
  endtask

  task automatic test_random();
    logic [31:0] va, vb, ea, eb;
    logic [1:0]  ca, cb;
    for (int t = 0; t < 300; t++) begin
      set_id_random();
      reset     = ($urandom_range(0, 99) < 3);
      bus.flush = ($urandom_range(0, 99) < 10);
      bus.stall = ($urandom_range(0, 99) < 25);
      bus.mem_rd = 5'($urandom_range(0, 3));  bus.mem_reg_write = 1'($urandom);  bus.mem_result = $urandom;
      bus.wb_rd  = 5'($urandom_range(0, 3));  bus.wb_reg_write  = 1'($urandom);  bus.wb_result  = $urandom;
      tick();
      fwd_ref(m.rs1, m.rs1_data, va, ca);
      fwd_ref(m.rs2, m.rs2_data, vb, cb);
      ea = (m.a_sel == 2'd0) ? va : (m.a_sel == 2'd1) ? m.pc : 32'h0;
      eb = m.b_imm ? m.imm : vb;
      checks++; if (bus.SrcA !== ea) begin errors++; $display("FAIL rnd%0d_srca got=%h exp=%h", t, bus.SrcA, ea); end
      checks++; if (bus.SrcB !== eb) begin errors++; $display("FAIL rnd%0d_srcb got=%h exp=%h", t, bus.SrcB, eb); end
      checks++; if (bus.ex_store_data !== vb) begin errors++; $display("FAIL rnd%0d_store got=%h exp=%h", t, bus.ex_store_data, vb); end
      checks++; if (bus.fwd_a !== ca || bus.fwd_b !== cb) begin errors++; $display("FAIL rnd%0d_fwd got=%0d/%0d exp=%0d/%0d", t, bus.fwd_a, bus.fwd_b, ca, cb); end
      checks++; if (bus.ex_valid !== m.valid || bus.ex_reg_write !== (m.rw & m.valid) || bus.ex_rd !== m.rd || bus.Operation !== m.op) begin
        errors++; $display("FAIL rnd%0d_ctrl got=v%0b w%0b rd%0d op%b exp=v%0b w%0b rd%0d op%b", t,
                           bus.ex_valid, bus.ex_reg_write, bus.ex_rd, bus.Operation, m.valid, m.rw & m.valid, m.rd, m.op);
      end
      $display("txn rnd%0d rst=%0b fl=%0b st=%0b v=%0b op=%b A=%h B=%h fa=%0d fb=%0d",
               t, reset, bus.flush, bus.stall, bus.ex_valid, bus.Operation, bus.SrcA, bus.SrcB, bus.fwd_a, bus.fwd_b);
    end
    reset = 1'b0;  bus.flush = 1'b0;  bus.stall = 1'b0;
  endtask

  initial begin
    m = '0;
    test_reset();
    test_basic_add();
    test_fwd_priority();
    test_rs0_and_imm();
    test_stall_hold();
    test_flush_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
